jtag_system_top: RTL and testbench
==================================

Name: jtag_system_top

Overview:
- JTAG debug subsystem: a pin-level JTAG TAP with a RISC-V-style DTM (IDCODE, DTMCS, DMI, BYPASS) drives a minimal Debug Module over an internal DMI.
- It also contains a single-hart stub that halts and resumes on Debug Module requests.
- Everything runs in the `clk` domain; TCK is oversampled.
- cJTAG is selectable but not implemented beyond mode reporting.

Parameters:
- IDCODE, 32'h1DEAD3FF, value shifted out by the IDCODE instruction; bit0 must be 1.
- IR_LEN, 8, instruction register length.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- jtag_pin0_i  in  1  TCK.
- jtag_pin1_i  in  1  TMS.
- jtag_pin1_o  out  1  TMSC output (cJTAG only); always 0.
- jtag_pin1_oen  out  1  pin1 output enable, active-low; always 1.
- jtag_pin2_i  in  1  TDI.
- jtag_pin3_o  out  1  TDO.
- jtag_pin3_oen  out  1  TDO enable, active-low.
- jtag_trst_n_i  in  1  TAP reset, active-low.
- mode_select  in  1  0 = JTAG, 1 = cJTAG.
- idcode  out  32  constant IDCODE.
- debug_req  out  1  halt request to the hart.
- hart_halted  out  1  hart stub halted status.
- active_mode  out  1  registered mode_select.

Behaviour:
- Reset values:
  - TAP in Test-Logic-Reset; IR = 0x01.
  - jtag_pin3_o = 0, jtag_pin3_oen = 1.
  - jtag_pin1_o = 0, jtag_pin1_oen = 1.
  - debug_req = 0, hart_halted = 0, active_mode = 0.
  - All DM registers cleared.
- Input synchronisation: pin0, pin1, pin2 and trst_n each pass through a 2-flop synchroniser.
  - Rising TCK edge: one clk pulse when synced TCK goes 0→1.
  - Falling TCK edge: one clk pulse when synced TCK goes 1→0.
  - TCK high and low times must each be ≥ 4 clk periods.
- Synced trst_n = 0, or active_mode = 1: TAP forced to Test-Logic-Reset, IR = 0x01, TDO disabled.
- TAP state machine: standard 16-state IEEE 1149.1, advanced on the rising-TCK pulse using the synced TMS.
  - Five TMS=1 edges reach Test-Logic-Reset from any state.
  - Entering Test-Logic-Reset loads IR = 0x01.
- Rising-edge operations:
  - Capture-IR loads 8'b0000_0001.
  - Shift-IR / Shift-DR shift LSB-first, TDI entering at the MSB.
  - Update-IR latches IR.
- Instruction decode:
  - 0x01 IDCODE: 32-bit DR; Capture loads IDCODE.
  - 0x10 DTMCS: 32-bit DR; Capture loads 0x00000071 (version 1, abits 7); Update is ignored.
  - 0x11 DMI: 41-bit DR = {addr[40:34], data[33:2], op[1:0]}.
  - All other codes, including 0xFF: 1-bit BYPASS; Capture loads 0.
- TDO timing:
  - jtag_pin3_o is updated on the falling-TCK pulse with the shift register LSB.
  - jtag_pin3_oen = 0 only while in Shift-IR or Shift-DR (applied at the falling edge); 1 otherwise.
- DMI:
  - Capture-DR loads {last_addr, last_rdata, 2'b00}; status is always 0 (success).
  - Update-DR op 1 (read): read DM[addr] into last_rdata in the same clk.
  - Update-DR op 2 (write): write DM[addr].
  - Op 0 and op 3 are no-ops.
  - last_addr is updated on every read and write.
  - The read result appears on the next DMI scan.
- DMCONTROL (0x10), write:
  - bit0 dmactive is stored.
  - If the written dmactive = 0: haltreq and resumeack are cleared, and resumereq is ignored.
  - If dmactive = 1: bit31 haltreq is stored.
  - bit30 resumereq (when dmactive = 1) is a one-cycle pulse.
  - A write with haltreq = 1 clears resumeack.
- DMCONTROL (0x10), read: returns {haltreq, 1'b0, 29'b0, dmactive}.
- DMSTATUS (0x11), read-only:
  - bits[3:0] version = 2; bit7 authenticated = 1.
  - bits 8, 9 anyhalted/allhalted = hart_halted.
  - bits 10, 11 anyrunning/allrunning = !hart_halted.
  - bits 16, 17 anyresumeack/allresumeack = resumeack.
- Any other address reads 0; writes to it are ignored.
- debug_req = dmactive & haltreq (registered).
- Hart stub:
  - hart_halted is set the clk after debug_req = 1.
  - On a resumereq pulse while halted and haltreq = 0: hart_halted clears and resumeack sets the next clk.
  - If haltreq and resumereq are written together, halt takes priority and resumereq is ignored.
- active_mode is registered from mode_select every clk.
  - A mode change resets the TAP.
  - It does not reset the DM.

Test Plan:
- Reset, 5 TMS=1 edges, then Shift-DR 32 bits → TDO yields 0x1DEAD3FF, LSB first; idcode = 0x1DEAD3FF.
- IR=0x11, DMI read addr 0x11, then NOP scan → data[33:2] = 0x00000C82, op field = 0.
- DMI write 0x10 = 0x80000001 → debug_req = 1 within 3 clk; hart_halted = 1; DMSTATUS read = 0x00000382.
- DMI write 0x10 = 0x40000001 → debug_req = 0, hart_halted = 0; DMSTATUS = 0x00030C82.
- IR=0xFF, shift pattern 1011 → TDO returns the pattern delayed by 1 bit.
- jtag_trst_n_i = 0 mid-Shift-DR → TAP returns to Test-Logic-Reset, IR = 0x01, pin3_oen = 1; DM state is retained.

Source files
------------

// File: rtl/jtag_system_top.sv
// JTAG debug subsystem: oversampled TAP with a RISC-V style DTM (IDCODE, DTMCS, DMI, BYPASS),
// a minimal Debug Module on the DMI, and a single-hart stub that halts and resumes.
module jtag_system_top #(
  parameter logic [31:0] IDCODE = 32'h1DEAD3FF,
  parameter int unsigned IR_LEN = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jtag_pin0_i,
  input  logic        jtag_pin1_i,
  output logic        jtag_pin1_o,
  output logic        jtag_pin1_oen,
  input  logic        jtag_pin2_i,
  output logic        jtag_pin3_o,
  output logic        jtag_pin3_oen,
  input  logic        jtag_trst_n_i,
  input  logic        mode_select,
  output logic [31:0] idcode,
  output logic        debug_req,
  output logic        hart_halted,
  output logic        active_mode
);

  typedef enum logic [3:0] {
    StTlr, StRti, StSelDr, StCapDr, StShDr, StEx1Dr, StPauseDr, StEx2Dr, StUpdDr,
    StSelIr, StCapIr, StShIr, StEx1Ir, StPauseIr, StEx2Ir, StUpdIr
  } tap_state_e;

  localparam logic [IR_LEN-1:0] IrIdcode = IR_LEN'(8'h01);
  localparam logic [IR_LEN-1:0] IrDtmcs  = IR_LEN'(8'h10);
  localparam logic [IR_LEN-1:0] IrDmi    = IR_LEN'(8'h11);

  logic [1:0]        r_tck_sync, r_tms_sync, r_tdi_sync, r_trst_sync;
  logic              r_tck_prev;
  logic              r_active_mode;
  tap_state_e        r_state, w_state_next;
  logic [IR_LEN-1:0] r_ir, r_ir_sh;
  logic [40:0]       r_dr, w_capture, w_dr_shifted;
  logic              r_tdo, r_tdo_oen;
  logic [6:0]        r_last_addr;
  logic [31:0]       r_last_rdata, w_dm_rdata;
  logic              r_dmactive, r_haltreq, r_resumeack, r_resume_pulse;
  logic              r_debug_req, r_halted;
  logic              w_tck, w_tms, w_tdi, w_rise, w_fall, w_force, w_dmi_update;
  logic [6:0]        w_dmi_addr;

  assign w_tck   = r_tck_sync[1];
  assign w_tms   = r_tms_sync[1];
  assign w_tdi   = r_tdi_sync[1];
  assign w_rise  = w_tck & ~r_tck_prev;
  assign w_fall  = ~w_tck & r_tck_prev;
  // TAP held in reset while TRST is asserted or cJTAG mode is selected
  assign w_force = ~r_trst_sync[1] | r_active_mode;

  // Two-flop synchronisers for the pins, TCK edge history and registered mode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tck_sync    <= 2'b00;
      r_tms_sync    <= 2'b00;
      r_tdi_sync    <= 2'b00;
      r_trst_sync   <= 2'b11;
      r_tck_prev    <= 1'b0;
      r_active_mode <= 1'b0;
    end else begin
      r_tck_sync    <= {r_tck_sync[0], jtag_pin0_i};
      r_tms_sync    <= {r_tms_sync[0], jtag_pin1_i};
      r_tdi_sync    <= {r_tdi_sync[0], jtag_pin2_i};
      r_trst_sync   <= {r_trst_sync[0], jtag_trst_n_i};
      r_tck_prev    <= w_tck;
      r_active_mode <= mode_select;
    end
  end

  // TAP state register, advanced on each rising TCK pulse
  always_ff @(posedge clk) begin
    if (rst || w_force) begin
      r_state <= StTlr;
    end else if (w_rise) begin
      r_state <= w_state_next;
    end
  end

  // IEEE 1149.1 next-state function
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StTlr:     w_state_next = w_tms ? StTlr     : StRti;
      StRti:     w_state_next = w_tms ? StSelDr   : StRti;
      StSelDr:   w_state_next = w_tms ? StSelIr   : StCapDr;
      StCapDr:   w_state_next = w_tms ? StEx1Dr   : StShDr;
      StShDr:    w_state_next = w_tms ? StEx1Dr   : StShDr;
      StEx1Dr:   w_state_next = w_tms ? StUpdDr   : StPauseDr;
      StPauseDr: w_state_next = w_tms ? StEx2Dr   : StPauseDr;
      StEx2Dr:   w_state_next = w_tms ? StUpdDr   : StShDr;
      StUpdDr:   w_state_next = w_tms ? StSelDr   : StRti;
      StSelIr:   w_state_next = w_tms ? StTlr     : StCapIr;
      StCapIr:   w_state_next = w_tms ? StEx1Ir   : StShIr;
      StShIr:    w_state_next = w_tms ? StEx1Ir   : StShIr;
      StEx1Ir:   w_state_next = w_tms ? StUpdIr   : StPauseIr;
      StPauseIr: w_state_next = w_tms ? StEx2Ir   : StPauseIr;
      StEx2Ir:   w_state_next = w_tms ? StUpdIr   : StShIr;
      StUpdIr:   w_state_next = w_tms ? StSelDr   : StRti;
      default:   w_state_next = StTlr;
    endcase
  end

  // Capture value and shifted value of the DR selected by the current instruction
  always_comb begin
    w_capture    = '0;
    w_dr_shifted = {40'b0, w_tdi};
    case (r_ir)
      IrIdcode: begin
        w_capture    = {9'b0, IDCODE};
        w_dr_shifted = {9'b0, w_tdi, r_dr[31:1]};
      end
      IrDtmcs: begin
        w_capture    = 41'h71;
        w_dr_shifted = {9'b0, w_tdi, r_dr[31:1]};
      end
      IrDmi: begin
        w_capture    = {r_last_addr, r_last_rdata, 2'b00};
        w_dr_shifted = {w_tdi, r_dr[40:1]};
      end
      default: begin
        w_capture    = '0;
        w_dr_shifted = {40'b0, w_tdi};
      end
    endcase
  end

  // IR/DR capture, shift and update on rising TCK; TDO driven on falling TCK
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ir      <= IrIdcode;
      r_ir_sh   <= '0;
      r_dr      <= '0;
      r_tdo     <= 1'b0;
      r_tdo_oen <= 1'b1;
    end else if (w_force) begin
      r_ir      <= IrIdcode;
      r_tdo_oen <= 1'b1;
    end else begin
      if (w_rise) begin
        case (r_state)
          StCapIr: r_ir_sh <= IR_LEN'(8'h01);
          StShIr:  r_ir_sh <= {w_tdi, r_ir_sh[IR_LEN-1:1]};
          StUpdIr: r_ir    <= r_ir_sh;
          StCapDr: r_dr    <= w_capture;
          StShDr:  r_dr    <= w_dr_shifted;
          default: ;
        endcase
        if (w_state_next == StTlr) r_ir <= IrIdcode;
      end
      if (w_fall) begin
        if (r_state == StShIr) begin
          r_tdo     <= r_ir_sh[0];
          r_tdo_oen <= 1'b0;
        end else if (r_state == StShDr) begin
          r_tdo     <= r_dr[0];
          r_tdo_oen <= 1'b0;
        end else begin
          r_tdo_oen <= 1'b1;
        end
      end
    end
  end

  assign w_dmi_addr   = r_dr[40:34];
  assign w_dmi_update = w_rise & ~w_force & (r_state == StUpdDr) & (r_ir == IrDmi);

  // Debug Module register read mux
  always_comb begin
    w_dm_rdata = '0;
    case (w_dmi_addr)
      7'h10: w_dm_rdata = {r_haltreq, 1'b0, 29'b0, r_dmactive};
      7'h11: w_dm_rdata = {14'b0, r_resumeack, r_resumeack, 4'b0, ~r_halted, ~r_halted,
                           r_halted, r_halted, 1'b1, 3'b0, 4'd2};
      default: w_dm_rdata = '0;
    endcase
  end

  // Debug Module registers, DMI access and hart stub
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_addr    <= '0;
      r_last_rdata   <= '0;
      r_dmactive     <= 1'b0;
      r_haltreq      <= 1'b0;
      r_resumeack    <= 1'b0;
      r_resume_pulse <= 1'b0;
      r_debug_req    <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      r_debug_req    <= r_dmactive & r_haltreq;
      r_resume_pulse <= 1'b0;
      // Resume is checked first so the stale debug_req of the resume cycle cannot re-halt
      if (r_resume_pulse && r_halted && !r_haltreq) begin
        r_halted    <= 1'b0;
        r_resumeack <= 1'b1;
      end else if (r_debug_req) begin
        r_halted <= 1'b1;
      end
      if (w_dmi_update) begin
        if (r_dr[1:0] == 2'b01) begin
          r_last_addr  <= w_dmi_addr;
          r_last_rdata <= w_dm_rdata;
        end else if (r_dr[1:0] == 2'b10) begin
          r_last_addr <= w_dmi_addr;
          if (w_dmi_addr == 7'h10) begin
            r_dmactive <= r_dr[2];
            if (!r_dr[2]) begin
              r_haltreq   <= 1'b0;
              r_resumeack <= 1'b0;
            end else begin
              r_haltreq <= r_dr[33];
              if (r_dr[33]) r_resumeack <= 1'b0;
              // haltreq wins over a simultaneous resumereq
              r_resume_pulse <= r_dr[32] & ~r_dr[33];
            end
          end
        end
      end
    end
  end

  assign jtag_pin1_o   = 1'b0;
  assign jtag_pin1_oen = 1'b1;
  assign jtag_pin3_o   = r_tdo;
  assign jtag_pin3_oen = r_tdo_oen;
  assign idcode        = IDCODE;
  assign debug_req     = r_debug_req;
  assign hart_halted   = r_halted;
  assign active_mode   = r_active_mode;

endmodule

// File: tb/tb_jtag_system_top.sv
// Directed bench for jtag_system_top: TAP scans via pin-level TCK/TMS/TDI, DMI access to the DM.
module tb_jtag_system_top;

  logic        clk = 1'b0;
  logic        rst;
  logic        tck, tms, tdi, trst_n, mode_sel;
  logic        pin1_o, pin1_oen, tdo, tdo_oen;
  logic [31:0] idcode;
  logic        debug_req, hart_halted, active_mode;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  jtag_system_top dut (
    .clk           (clk),
    .rst           (rst),
    .jtag_pin0_i   (tck),
    .jtag_pin1_i   (tms),
    .jtag_pin1_o   (pin1_o),
    .jtag_pin1_oen (pin1_oen),
    .jtag_pin2_i   (tdi),
    .jtag_pin3_o   (tdo),
    .jtag_pin3_oen (tdo_oen),
    .jtag_trst_n_i (trst_n),
    .mode_select   (mode_sel),
    .idcode        (idcode),
    .debug_req     (debug_req),
    .hart_halted   (hart_halted),
    .active_mode   (active_mode)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One TCK period; returns TDO as driven before this rising edge
  task automatic tck_cycle(input logic t_ms, input logic t_di, output logic t_do);
    t_do = tdo;
    tms  = t_ms;
    tdi  = t_di;
    #40;
    tck = 1'b1;
    #80;
    tck = 1'b0;
    #80;
  endtask

  // From Run-Test/Idle: scan n DR bits LSB first, return to Run-Test/Idle
  task automatic scan_dr(input logic [40:0] din, input int n, output logic [40:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < n; i++) begin
      tck_cycle(i == n - 1, din[i], b);
      dout[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic scan_ir(input logic [7:0] din, output logic [7:0] dout);
    logic b;
    dout = '0;
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    for (int i = 0; i < 8; i++) begin
      tck_cycle(i == 7, din[i], b);
      dout[i] = b;
    end
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
  endtask

  task automatic dmi_write(input logic [6:0] addr, input logic [31:0] data);
    logic [40:0] d;
    scan_dr({addr, data, 2'b10}, 41, d);
  endtask

  // Read request followed by a NOP scan that carries the result
  task automatic dmi_read(input logic [6:0] addr, output logic [40:0] d);
    scan_dr({addr, 32'h0, 2'b01}, 41, d);
    scan_dr(41'h0, 41, d);
  endtask

  initial begin
    logic [40:0] d;
    logic [7:0]  ir_out;
    logic        b;

    rst = 1'b1; tck = 1'b0; tms = 1'b1; tdi = 1'b0; trst_n = 1'b1; mode_sel = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_tdo", tdo, 0);
    check("rst_tdo_oen", tdo_oen, 1);
    check("rst_pin1_o", pin1_o, 0);
    check("rst_pin1_oen", pin1_oen, 1);
    check("rst_debug_req", debug_req, 0);
    check("rst_hart_halted", hart_halted, 0);
    check("rst_active_mode", active_mode, 0);
    check("idcode_port", idcode, 32'h1DEAD3FF);

    // IDCODE is the reset instruction
    repeat (5) tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    scan_dr(41'h0, 32, d);
    check("idcode_scan", d, 41'h1DEAD3FF);
    check("oen_idle", tdo_oen, 1);

    // DTMCS
    scan_ir(8'h10, ir_out);
    check("ir_capture", ir_out, 8'h01);
    scan_dr(41'h0, 32, d);
    check("dtmcs_scan", d, 41'h71);

    // DMI read of DMSTATUS while running
    scan_ir(8'h11, ir_out);
    dmi_read(7'h11, d);
    check("dmstatus_run_data", d[33:2], 32'h00000C82);
    check("dmstatus_run_op", d[1:0], 0);
    check("dmstatus_run_addr", d[40:34], 7'h11);

    // Halt
    dmi_write(7'h10, 32'h80000001);
    check("halt_debug_req", debug_req, 1);
    check("halt_hart_halted", hart_halted, 1);
    dmi_read(7'h11, d);
    check("dmstatus_halted", d[33:2], 32'h00000382);
    dmi_read(7'h10, d);
    check("dmcontrol_halt", d[33:2], 32'h80000001);

    // Resume
    dmi_write(7'h10, 32'h40000001);
    check("resume_debug_req", debug_req, 0);
    check("resume_hart_halted", hart_halted, 0);
    dmi_read(7'h11, d);
    check("dmstatus_resumed", d[33:2], 32'h00030C82);
    dmi_read(7'h10, d);
    check("dmcontrol_resume", d[33:2], 32'h00000001);
    dmi_read(7'h05, d);
    check("unmapped_read", d[33:2], 32'h0);

    // BYPASS: pattern 1011 comes back one bit late
    scan_ir(8'hFF, ir_out);
    scan_dr(41'b1011, 4, d);
    check("bypass", d[3:0], 4'b0110);

    // TRST in the middle of Shift-DR
    scan_ir(8'h11, ir_out);
    dmi_write(7'h10, 32'h80000001);
    tck_cycle(1'b1, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b0, b);
    tck_cycle(1'b0, 1'b1, b);
    tck_cycle(1'b0, 1'b1, b);
    check("shift_oen", tdo_oen, 0);
    trst_n = 1'b0;
    repeat (10) @(negedge clk);
    check("trst_oen", tdo_oen, 1);
    check("trst_debug_req", debug_req, 1);
    check("trst_hart_halted", hart_halted, 1);
    trst_n = 1'b1;
    repeat (10) @(negedge clk);
    tck_cycle(1'b0, 1'b0, b);
    scan_dr(41'h0, 32, d);
    check("trst_idcode", d, 41'h1DEAD3FF);
    scan_ir(8'h11, ir_out);
    dmi_read(7'h10, d);
    check("trst_dm_kept", d[33:2], 32'h80000001);

    // cJTAG mode select resets the TAP but not the DM
    mode_sel = 1'b1;
    repeat (5) @(negedge clk);
    check("mode_active", active_mode, 1);
    check("mode_pin1_o", pin1_o, 0);
    check("mode_oen", tdo_oen, 1);
    mode_sel = 1'b0;
    repeat (5) @(negedge clk);
    check("mode_back", active_mode, 0);
    check("mode_dm_kept", hart_halted, 1);
    tck_cycle(1'b0, 1'b0, b);
    scan_dr(41'h0, 32, d);
    check("mode_idcode", d, 41'h1DEAD3FF);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
